operand_pair_streamer: RTL and testbench
========================================

OPERAND_PAIR_STREAMER -- requirements
Module: operand_pair_streamer

Interface
REQ-001 SHALL have parameter REGISTER_SIZE, default 32, block width in bits.
REQ-002 SHALL have parameter BITS_IN_NUM, default 4096, operand width in bits; BLOCKS_PER_NUM = BITS_IN_NUM/REGISTER_SIZE (128).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per input FIFO (power of two, >=2).
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk_in  input  1  rising-edge clock; rst_n_in  input  1  synchronous active-low reset.
REQ-005 n_data_in  input  REGISTER_SIZE  n operand block, LSB block first.
REQ-006 n_valid_in  input  1  n block present.
REQ-007 n_ready_out  output  1  n block accepted when n_valid_in && n_ready_out.
REQ-008 m_data_in / m_valid_in / m_ready_out  same widths and rules as n for operand m.
REQ-009 mult_ready_in  input  1  multiplier idle (multiplier ready_out).
REQ-010 mult_final_in  input  1  multiplier last-output pulse (multiplier final_out).
REQ-011 n_out, m_out  output  REGISTER_SIZE  paired blocks to multiplier n_in/m_in.
REQ-012 valid_out  output  1  n_out/m_out hold a pair (to multiplier valid_in).
REQ-013 busy_out  output  1  frame in progress (state != IDLE).

Function
REQ-014 Each input SHALL feed its own FIFO of FIFO_DEPTH; x_ready_out = FIFO not full; push on x_valid_in && x_ready_out.
REQ-015 A pop SHALL remove one entry from both FIFOs simultaneously and only when both are non-empty and the state permits; no single-side pop ever.
REQ-016 Popped heads SHALL be registered into n_out/m_out with valid_out=1 in the next cycle; valid_out=0 in any cycle following a non-pop cycle; n_out/m_out hold last value when valid_out=0.
REQ-017 Latency: block accepted on both sides in cycle t with empty FIFOs and state permitting SHALL appear with valid_out in cycle t+2.
REQ-018 States: IDLE, STREAM, WAIT_DONE.
REQ-019 IDLE: pop permitted only when mult_ready_in=1; first pop -> STREAM, pair counter = 1.
REQ-020 STREAM: pop whenever both non-empty (mult_ready_in ignored); counter increments per pop; pop making counter = BLOCKS_PER_NUM -> WAIT_DONE.
REQ-021 WAIT_DONE: no pops; valid_out SHALL be 0 from the cycle after the last pair's valid_out; on mult_final_in=1 -> IDLE, counter = 0.
REQ-022 Exactly BLOCKS_PER_NUM pairs SHALL be emitted per frame; blocks beyond that stay queued for the next frame, order preserved.
REQ-023 Gaps within a frame (either FIFO empty) are legal and SHALL only pause valid_out; pairing n[i] with m[i] SHALL hold regardless of skew.
REQ-024 Simultaneous push and pop on one FIFO SHALL leave occupancy unchanged; push when full cannot occur (ready low).
REQ-025 mult_final_in outside WAIT_DONE SHALL be ignored.
REQ-026 Counter width SHALL be $clog2(BLOCKS_PER_NUM)+1 bits; no wrap within a frame.

Reset
REQ-027 While rst_n_in=0 at a clock edge: FIFOs emptied, state IDLE, counter 0, n_out=0, m_out=0, valid_out=0.
REQ-028 n_ready_out, m_ready_out, busy_out SHALL be 0 while rst_n_in=0.
REQ-029 Reset mid-frame SHALL discard the partial frame and queued blocks; the multiplier shares the reset, so no resynchronisation is attempted.

Structure
REQ-030 Package bignum_pkg SHALL hold REGISTER_SIZE, BITS_IN_NUM, BLOCKS_PER_NUM defaults and the streamer state enum.
REQ-031 One sub-module stream_fifo (synchronous, registered count, full/empty flags) SHALL be instantiated twice.

Verification
REQ-032 Both streams valid continuously, n[i]=i, m[i]=1000+i, mult_ready_in=1 -> valid_out high 128 consecutive cycles starting 2 cycles after first accept, pair k = (k, 1000+k), then 0.
REQ-033 m stream starts 10 cycles after n -> n_ready_out low after 4 n accepts, first valid_out 2 cycles after first m accept, pairing intact.
REQ-034 m_valid_in toggles every cycle -> valid_out alternates, exactly 128 pairs, in order.
REQ-035 Second frame presented immediately, mult_final_in pulsed 300 cycles after pair 128 -> no valid_out in between; frame 2 begins only after return to IDLE with mult_ready_in=1.
REQ-036 rst_n_in low for 1 cycle after 50 pairs -> next cycle valid_out=0, readies 0 during reset; new frame afterwards emits 128 pairs from its first block.
REQ-037 Connected to fsm_multiplier, n block0=3, m block0=5, others 0 -> product block0=15, all other blocks 0, final_out once.

Source files
------------

// File: rtl/bignum_pkg.sv
// -----------------------------------------------------------------------------
// bignum_pkg
// Shared definitions for the big-number datapath: default block and operand
// widths, the derived number of blocks per operand, and the state encoding of
// the operand pair streamer.
// No ports (package).
// -----------------------------------------------------------------------------
package bignum_pkg;

   localparam int REGISTER_SIZE_DEF  = 32;
   localparam int BITS_IN_NUM_DEF    = 4096;
   localparam int BLOCKS_PER_NUM_DEF = BITS_IN_NUM_DEF / REGISTER_SIZE_DEF;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_STREAM    = 2'd1,
      ST_WAIT_DONE = 2'd2
   } streamer_state_e;

endpackage

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// Synchronous FIFO with a registered occupancy count and full/empty flags.
// The head entry is always visible on data_out; pop_in consumes it.
// Ports:
//   clk_in     rising-edge clock
//   rst_n_in   synchronous active-low reset (empties the FIFO)
//   push_in    write data_in (ignored while full)
//   data_in    entry to write
//   pop_in     remove the head entry (ignored while empty)
//   data_out   current head entry
//   full_out   FIFO holds DEPTH entries
//   empty_out  FIFO holds no entries
// -----------------------------------------------------------------------------
module stream_fifo
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             push_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full_out,
   output logic             empty_out
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_out  = (count_q == FULL_CNT);
   assign empty_out = (count_q == '0);
   assign push_ok   = push_in && !full_out;
   assign pop_ok    = pop_in && !empty_out;
   assign data_out  = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an empty FIFO never exposes its contents.
   always_ff @(posedge clk_in) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_in;
   end

endmodule

// File: rtl/operand_pair_streamer.sv
// -----------------------------------------------------------------------------
// operand_pair_streamer
// Buffers the n and m operand block streams in two FIFOs and hands them to the
// multiplier as aligned (n[i], m[i]) pairs, exactly BLOCKS_PER_NUM pairs per
// frame. A frame starts only when the multiplier is idle and ends only after
// the multiplier reports its last output.
// Ports:
//   clk_in, rst_n_in          clock, synchronous active-low reset
//   n_data_in/n_valid_in      n operand block stream (LSB block first)
//   n_ready_out               n FIFO not full
//   m_data_in/m_valid_in      m operand block stream
//   m_ready_out               m FIFO not full
//   mult_ready_in             multiplier idle
//   mult_final_in             multiplier last-output pulse
//   n_out, m_out, valid_out   registered block pair for the multiplier
//   busy_out                  frame in progress
// -----------------------------------------------------------------------------
module operand_pair_streamer
   import bignum_pkg::*;
#(
   parameter int REGISTER_SIZE = REGISTER_SIZE_DEF,
   parameter int BITS_IN_NUM   = BITS_IN_NUM_DEF,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic [REGISTER_SIZE-1:0] n_data_in,
   input  logic                     n_valid_in,
   output logic                     n_ready_out,
   input  logic [REGISTER_SIZE-1:0] m_data_in,
   input  logic                     m_valid_in,
   output logic                     m_ready_out,
   input  logic                     mult_ready_in,
   input  logic                     mult_final_in,
   output logic [REGISTER_SIZE-1:0] n_out,
   output logic [REGISTER_SIZE-1:0] m_out,
   output logic                     valid_out,
   output logic                     busy_out
);

   localparam int BLOCKS_PER_NUM = BITS_IN_NUM / REGISTER_SIZE;
   localparam int CNT_W          = $clog2(BLOCKS_PER_NUM) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCKS_PER_NUM);

   streamer_state_e          state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [REGISTER_SIZE-1:0] n_head, m_head;
   logic                     n_full, n_empty, m_full, m_empty;
   logic                     n_push, m_push;
   logic                     pop_permit, pop;
   logic [REGISTER_SIZE-1:0] n_out_q, m_out_q;
   logic                     valid_q;

   // Readies are forced low while reset is held so no block is accepted into
   // a FIFO that is being flushed.
   assign n_ready_out = !n_full && rst_n_in;
   assign m_ready_out = !m_full && rst_n_in;
   assign n_push      = n_valid_in && n_ready_out;
   assign m_push      = m_valid_in && m_ready_out;

   stream_fifo #(
      .WIDTH (REGISTER_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_n_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .push_in   (n_push),
      .data_in   (n_data_in),
      .pop_in    (pop),
      .data_out  (n_head),
      .full_out  (n_full),
      .empty_out (n_empty)
   );

   stream_fifo #(
      .WIDTH (REGISTER_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_m_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .push_in   (m_push),
      .data_in   (m_data_in),
      .pop_in    (pop),
      .data_out  (m_head),
      .full_out  (m_full),
      .empty_out (m_empty)
   );

   // State register and pair counter.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               cnt_d   = CNT_W'(1);
               state_d = (LAST_CNT == CNT_W'(1)) ? ST_WAIT_DONE : ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (pop) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q + 1'b1 == LAST_CNT) state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (mult_final_in) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic: a frame may only start on an idle multiplier; once
   // streaming, pairs flow whenever both sides have a block.
   always_comb begin
      pop_permit = 1'b0;
      busy_out   = 1'b0;
      case (state_q)
         ST_IDLE:      pop_permit = mult_ready_in;
         ST_STREAM:    pop_permit = 1'b1;
         default:      pop_permit = 1'b0;
      endcase
      pop      = pop_permit && !n_empty && !m_empty;
      busy_out = (state_q != ST_IDLE) && rst_n_in;
   end

   // Pair output register: valid follows the pop by one cycle, data holds
   // between pairs.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         n_out_q <= '0;
         m_out_q <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= pop;
         if (pop) begin
            n_out_q <= n_head;
            m_out_q <= m_head;
         end
      end
   end

   assign n_out     = n_out_q;
   assign m_out     = m_out_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_operand_pair_streamer.sv
// -----------------------------------------------------------------------------
// tb_operand_pair_streamer
// Drives randomized and directed operand streams into operand_pair_streamer
// and compares every cycle against a queue-based reference model of the
// pairing, framing and handshake rules.
// -----------------------------------------------------------------------------
module tb_operand_pair_streamer;

   localparam int RS    = 32;
   localparam int BN    = 4096;
   localparam int DEPTH = 4;
   localparam int BLK   = BN / RS;

   logic          clk_in        = 1'b0;
   logic          rst_n_in      = 1'b0;
   logic [RS-1:0] n_data_in     = '0;
   logic          n_valid_in    = 1'b0;
   logic [RS-1:0] m_data_in     = '0;
   logic          m_valid_in    = 1'b0;
   logic          mult_ready_in = 1'b0;
   logic          mult_final_in = 1'b0;
   logic          n_ready_out, m_ready_out, valid_out, busy_out;
   logic [RS-1:0] n_out, m_out;

   always #5 clk_in = ~clk_in;

   operand_pair_streamer #(
      .REGISTER_SIZE (RS),
      .BITS_IN_NUM   (BN),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .n_data_in     (n_data_in),
      .n_valid_in    (n_valid_in),
      .n_ready_out   (n_ready_out),
      .m_data_in     (m_data_in),
      .m_valid_in    (m_valid_in),
      .m_ready_out   (m_ready_out),
      .mult_ready_in (mult_ready_in),
      .mult_final_in (mult_final_in),
      .n_out         (n_out),
      .m_out         (m_out),
      .valid_out     (valid_out),
      .busy_out      (busy_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Reference model: queues are the FIFO contents, frame progress is a pair
   // count plus "frame open" / "waiting for final" flags.
   logic [RS-1:0] nq[$];
   logic [RS-1:0] mq[$];
   int            md_cnt    = 0;
   bit            md_active = 0;
   bit            md_wait   = 0;
   bit            exp_valid = 0;
   logic [RS-1:0] exp_n     = '0;
   logic [RS-1:0] exp_m     = '0;
   bit            n_acc     = 0;
   bit            m_acc     = 0;
   int            obs_pairs = 0;

   always @(negedge clk_in) begin
      bit pop, n_rdy, m_rdy;
      n_rdy = (nq.size() < DEPTH);
      m_rdy = (mq.size() < DEPTH);
      chk("valid_out", valid_out, exp_valid);
      chk("n_out", n_out, exp_n);
      chk("m_out", m_out, exp_m);
      if (valid_out === 1'b1) obs_pairs++;
      if (!rst_n_in) begin
         chk("n_ready_rst", n_ready_out, 0);
         chk("m_ready_rst", m_ready_out, 0);
         chk("busy_rst", busy_out, 0);
         nq.delete();
         mq.delete();
         md_cnt    = 0;
         md_active = 0;
         md_wait   = 0;
         exp_valid = 0;
         exp_n     = '0;
         exp_m     = '0;
         n_acc     = 0;
         m_acc     = 0;
      end else begin
         chk("n_ready", n_ready_out, n_rdy);
         chk("m_ready", m_ready_out, m_rdy);
         chk("busy", busy_out, md_active);
         pop = 0;
         if (md_wait) begin
            if (mult_final_in) begin
               md_wait   = 0;
               md_active = 0;
               md_cnt    = 0;
            end
         end else if (nq.size() > 0 && mq.size() > 0 && (md_active || mult_ready_in)) begin
            pop       = 1;
            md_active = 1;
            md_cnt++;
            if (md_cnt == BLK) md_wait = 1;
         end
         exp_valid = pop;
         if (pop) begin
            exp_n = nq.pop_front();
            exp_m = mq.pop_front();
         end
         n_acc = n_valid_in && n_rdy;
         m_acc = m_valid_in && m_rdy;
         if (n_acc) nq.push_back(n_data_in);
         if (m_acc) mq.push_back(m_data_in);
      end
   end

   logic [RS-1:0] ntab [0:511];
   logic [RS-1:0] mtab [0:511];
   int            n_sent, m_sent;

   function automatic bit pat(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return cyc[0];
         default: return ($urandom_range(0, 1) == 1);
      endcase
   endfunction

   // nblk blocks per side; modes 0=continuous 1=every other cycle 2=random.
   // rdy_mode 0 keeps mult_ready_in high, 1 randomizes it. rst_at>0 pulses
   // reset once that many pairs have been seen and then restarts the frame.
   task automatic run_phase(input string name, input int nblk, input int n_mode,
                            input int m_mode, input int m_delay, input int rdy_mode,
                            input int fin_delay, input bit spurious, input int rst_at,
                            input bit directed);
      int cyc      = 0;
      int wcnt     = 0;
      int snap     = -1;
      bit rst_done = 0;
      for (int k = 0; k < 512; k++) begin
         ntab[k] = directed ? RS'(k) : RS'($urandom());
         mtab[k] = directed ? RS'(1000 + k) : RS'($urandom());
      end
      n_sent    = 0;
      m_sent    = 0;
      obs_pairs = 0;
      forever begin
         @(posedge clk_in);
         #1;
         if (n_acc) n_sent++;
         if (m_acc) m_sent++;
         rst_n_in = 1'b1;
         if (rst_done && snap < 0) begin
            snap = obs_pairs;
            chk({name, "_post_rst_valid"}, valid_out, 0);
            chk({name, "_post_rst_n_out"}, n_out, 0);
         end
         if (rst_at > 0 && !rst_done && obs_pairs >= rst_at) begin
            rst_n_in = 1'b0;
            rst_done = 1;
            n_sent   = 0;
            m_sent   = 0;
         end
         cyc++;
         if (md_wait) wcnt++;
         else wcnt = 0;
         n_valid_in    = rst_n_in && (n_sent < nblk) && pat(n_mode, cyc);
         n_data_in     = ntab[n_sent];
         m_valid_in    = rst_n_in && (m_sent < nblk) && (cyc > m_delay) && pat(m_mode, cyc);
         m_data_in     = mtab[m_sent];
         mult_ready_in = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
         mult_final_in = (md_wait && wcnt == fin_delay) ||
                         (spurious && !md_wait && $urandom_range(0, 15) == 0);
         if (n_sent == nblk && m_sent == nblk && !md_active && nq.size() == 0 &&
             mq.size() == 0 && rst_n_in)
            break;
         if (cyc > 20000) begin
            chk({name, "_timeout"}, 1, 0);
            break;
         end
      end
      n_valid_in    = 1'b0;
      m_valid_in    = 1'b0;
      mult_final_in = 1'b0;
      @(posedge clk_in);
      #1;
      if (rst_at > 0) chk({name, "_pairs"}, obs_pairs - snap, nblk);
      else            chk({name, "_pairs"}, obs_pairs, nblk);
   endtask

   initial begin
      repeat (3) @(posedge clk_in);
      #1;
      chk("reset_valid", valid_out, 0);
      chk("reset_n_out", n_out, 0);
      chk("reset_m_out", m_out, 0);
      chk("reset_n_ready", n_ready_out, 0);
      chk("reset_m_ready", m_ready_out, 0);
      chk("reset_busy", busy_out, 0);
      rst_n_in = 1'b1;
      run_phase("cont",    BLK,     0, 0, 0,  0, 20,  0, 0,  1);
      run_phase("skew",    BLK,     0, 0, 10, 0, 5,   0, 0,  0);
      run_phase("toggle",  BLK,     0, 1, 0,  0, 3,   0, 0,  0);
      run_phase("two_frm", 2 * BLK, 0, 0, 0,  1, 300, 0, 0,  1);
      run_phase("mid_rst", BLK,     0, 0, 0,  0, 4,   0, 50, 1);
      run_phase("random",  3 * BLK, 2, 2, $urandom_range(0, 20), 1,
                $urandom_range(1, 12), 1, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
